concat_channels_n: RTL and testbench
====================================

Name: concat_channels_n

Overview:
Parametrised successor to the two-stream channel concatenator. It accepts two independent per-pixel channel streams, left (CH_L words per pixel) and right (CH_R words per pixel), each with its own valid. It emits one merged stream of CH_L+CH_R words per pixel at up to 1 word/cycle, in a selectable order, with pixel/frame flags re-aligned to the merged pixel. It sits between two conv-layer outputs and the downstream max_pool/conv stage.

Parameters:
DATA_WIDTH, 8, word width (signed data).
CH_L, 16, words per pixel on the left input (>=1).
CH_R, 16, words per pixel on the right input (>=1).
FIFO_DEPTH, 64, words per data FIFO (power of 2, >= max(CH_L,CH_R)).
TAG_DEPTH, 4, pixel-tag FIFO entries (power of 2).
ORDER, 0, 0 = left words first, 1 = right words first.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
valid_l_i  in  1  left word valid
data_l_i  in  DATA_WIDTH  left word
valid_r_i  in  1  right word valid
data_r_i  in  DATA_WIDTH  right word
sop_i  in  1  start of line, qualified with first left word of a pixel
eop_i  in  1  end of line, qualified with last left word of a pixel
sof_i  in  1  start of frame, same qualification as sop_i
eof_i  in  1  end of frame, same qualification as eop_i
data_o  out  DATA_WIDTH  merged word
data_valid_o  out  1  merged word valid
sop_o, eop_o, sof_o, eof_o  out  1 each  flags on merged stream
ovf_o  out  1  sticky overflow error

Behaviour:
- Reset (async, active-high): all counters 0, FIFOs empty, FSM IDLE; data_o=0, data_valid_o=0, all flag outputs 0, ovf_o=0. Reset asserted mid-pixel discards all buffered data; the first left word after release is word 0 of a new pixel.
- Left side: word counter wl (0..CH_L-1) advances on valid_l_i and wraps. At wl==0, sop_i/sof_i are captured. At wl==CH_L-1, eop_i/eof_i are captured, a tag {sop,eop,sof,eof} is pushed to the tag FIFO, and the left-pixel counter pl increments.
- Right side: word counter wr (0..CH_R-1). At wr==CH_R-1 the right-pixel counter pr increments.
- pl and pr are log2(TAG_DEPTH)+1 bits. They decrement when the FSM starts a pixel. Simultaneous increment and decrement leaves the counter unchanged.
- FSM states:
  - IDLE: if pl>0 and pr>0, pop the tag and go to FIRST.
  - FIRST: read CH_first words from the first FIFO, then go to SECOND.
  - SECOND: read CH_second words. On the last read, go to FIRST (back-to-back, no bubble) if another pixel is ready, else go to IDLE.
  - FIRST/SECOND map to L/R per ORDER.
- FIFO reads have 1-cycle latency. Output is registered, so data_valid_o follows the read enable by 2 cycles. Latency from the cycle the pixel's last input word (whichever side completes later) is written to its first output word: 4 cycles.
- Flags: sop_o and sof_o assert with output word 0 of the pixel; eop_o and eof_o assert with output word CH_L+CH_R-1. Flags are 0 whenever data_valid_o=0.
- Output is contiguous within a pixel: exactly CH_L+CH_R consecutive valid cycles.
- Overflow:
  - A write to a full data FIFO, or a tag push to a full tag FIFO, is dropped and sets ovf_o.
  - ovf_o clears only on reset.
  - The word counter still advances on the dropped write, so pixel framing is preserved.
- Simultaneous read and write on a full FIFO is allowed: read frees a slot in the same cycle, and the write is accepted.
- Pointers wrap modulo depth. Full and empty are derived from an extra MSB on the pointers.

Decomposition:
- Package concat_pkg: typedef tag_t (sop, eop, sof, eof), FSM enum state_t {IDLE, FIRST, SECOND}, function clog2-based width constants.
- Sub-module sync_fifo (params WIDTH, DEPTH). Interfaces: wr/rd, full/empty, registered q, 1-cycle read latency, async active-high reset. Instantiated three times: left data, right data, tags.

Test Plan:
1. CH_L=CH_R=16, ORDER=0: left 0..15 and right 100..115 driven simultaneously -> 32 contiguous valid words 0..15 then 100..115; first output 4 cycles after the last write; sop_o on word 0, eop_o on word 31.
2. ORDER=1, CH_L=4, CH_R=2: left {1,2,3,4}, right {9,8} -> output 9,8,1,2,3,4.
3. Skew: right pixel arrives 20 cycles after left -> no output until the right pixel completes, then 32 words. Three pixels queued -> 96 valid cycles with no bubble.
4. Frame flags: 2-pixel frame, sof_i on pixel 0 word 0, eof_i on pixel 1 word 15 -> sof_o on output word 0 only, eof_o on output word 63 only.
5. Overflow: FIFO_DEPTH=16, drive 2 left pixels with no right input -> ovf_o rises on the 17th left word and stays 1; later right input still produces framed pixels.
6. Reset asserted mid-output (word 10 of 32) -> outputs 0 immediately. After release, a fresh pixel pair produces a clean 32-word pixel with correct flags.

Source files
------------

// File: rtl/concat_channels_n_pkg.sv
// Shared types and width helper for the two-stream channel concatenator.
package concat_pkg;

  typedef struct packed {
    logic sop;
    logic eop;
    logic sof;
    logic eof;
  } tag_t;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/concat_channels_n_if.sv
// Stream bundle: two input channel streams with pixel flags, one merged output stream.
interface concat_channels_n_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid_l_i;
  logic [DATA_WIDTH-1:0] data_l_i;
  logic                  valid_r_i;
  logic [DATA_WIDTH-1:0] data_r_i;
  logic                  sop_i;
  logic                  eop_i;
  logic                  sof_i;
  logic                  eof_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  data_valid_o;
  logic                  sop_o;
  logic                  eop_o;
  logic                  sof_o;
  logic                  eof_o;
  logic                  ovf_o;

  modport master (
    output valid_l_i, data_l_i, valid_r_i, data_r_i, sop_i, eop_i, sof_i, eof_i,
    input  data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, ovf_o
  );

  modport slave (
    input  valid_l_i, data_l_i, valid_r_i, data_r_i, sop_i, eop_i, sof_i, eof_i,
    output data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, ovf_o
  );
endinterface

// File: rtl/concat_channels_n_sync_fifo.sv
// Synchronous FIFO, registered read data with 1-cycle latency; write while full is
// accepted only if a read frees a slot in the same cycle.
module sync_fifo
  import concat_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] q_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] q_q;
  logic             rd_ok, wr_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_ok   = rd_i && !empty_o;
  assign wr_ok   = wr_i && (!full_o || rd_ok);
  assign q_o     = q_q;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      q_q    <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + (AW+1)'(1);
      if (rd_ok) begin
        rptr_q <= rptr_q + (AW+1)'(1);
        q_q    <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/concat_channels_n.sv
// Merges a left and a right per-pixel channel stream into one stream of CH_L+CH_R
// words per pixel, with pixel/frame flags re-aligned to the merged pixel.
module concat_channels_n
  import concat_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CH_L       = 16,
  parameter int CH_R       = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int TAG_DEPTH  = 4,
  parameter int ORDER      = 0
) (
  input logic                clk,
  input logic                reset,
  concat_channels_n_if.slave bus
);
  localparam int WLW       = cnt_width(CH_L);
  localparam int WRW       = cnt_width(CH_R);
  localparam int CW        = cnt_width((CH_L > CH_R) ? CH_L : CH_R);
  localparam int PW        = $clog2(TAG_DEPTH) + 1;
  localparam int CH_FIRST  = (ORDER == 0) ? CH_L : CH_R;
  localparam int CH_SECOND = (ORDER == 0) ? CH_R : CH_L;

  logic [WLW-1:0]        wl_q;
  logic [WRW-1:0]        wr_q;
  logic                  sop_cap_q, sof_cap_q;
  logic [PW-1:0]         pl_q, pl_d, pr_q, pr_d;
  state_t                state_q, state_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;
  logic                  wl_first, wl_last, wr_last, tag_push, pix_r_done;
  logic                  rd_first, rd_second, rd_l, rd_r, start, ready;
  tag_t                  tag_in, tag_out, pix_tag_q;
  logic [DATA_WIDTH-1:0] ql, qr;
  logic                  full_l, empty_l, full_r, empty_r, full_t, empty_t;
  logic                  drop_l, drop_r, drop_t;
  logic                  v1_q, sel_l1_q, first1_q, last1_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, sop_q, eop_q, sof_q, eof_q, ovf_q;

  assign wl_first   = (wl_q == '0);
  assign wl_last    = (wl_q == WLW'(CH_L - 1));
  assign wr_last    = (wr_q == WRW'(CH_R - 1));
  assign tag_push   = bus.valid_l_i && wl_last;
  assign pix_r_done = bus.valid_r_i && wr_last;

  // With CH_L==1 the first and last left word coincide, so take start flags live.
  always_comb begin
    tag_in.sop = wl_first ? bus.sop_i : sop_cap_q;
    tag_in.sof = wl_first ? bus.sof_i : sof_cap_q;
    tag_in.eop = bus.eop_i;
    tag_in.eof = bus.eof_i;
  end

  assign drop_l = bus.valid_l_i && full_l && !(rd_l && !empty_l);
  assign drop_r = bus.valid_r_i && full_r && !(rd_r && !empty_r);
  assign drop_t = tag_push && full_t && !(start && !empty_t);

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_l (
    .clk(clk), .reset(reset), .wr_i(bus.valid_l_i), .din_i(bus.data_l_i),
    .rd_i(rd_l), .q_o(ql), .full_o(full_l), .empty_o(empty_l)
  );
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_r (
    .clk(clk), .reset(reset), .wr_i(bus.valid_r_i), .din_i(bus.data_r_i),
    .rd_i(rd_r), .q_o(qr), .full_o(full_r), .empty_o(empty_r)
  );
  sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(TAG_DEPTH)) u_fifo_t (
    .clk(clk), .reset(reset), .wr_i(tag_push), .din_i(tag_in),
    .rd_i(start), .q_o(tag_out), .full_o(full_t), .empty_o(empty_t)
  );

  always_comb begin
    pl_d = pl_q;
    pr_d = pr_q;
    case ({tag_push, start})
      2'b10:   pl_d = pl_q + PW'(1);
      2'b01:   pl_d = pl_q - PW'(1);
      default: pl_d = pl_q;
    endcase
    case ({pix_r_done, start})
      2'b10:   pr_d = pr_q + PW'(1);
      2'b01:   pr_d = pr_q - PW'(1);
      default: pr_d = pr_q;
    endcase
  end

  assign ready = (pl_q != '0) && (pr_q != '0);

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rd_first  = 1'b0;
    rd_second = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready) begin
          start   = 1'b1;
          state_d = FIRST;
          rcnt_d  = '0;
        end
      end
      FIRST: begin
        rd_first = 1'b1;
        if (rcnt_q == CW'(CH_FIRST - 1)) begin
          rcnt_d  = '0;
          state_d = SECOND;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      SECOND: begin
        rd_second = 1'b1;
        if (rcnt_q == CW'(CH_SECOND - 1)) begin
          rcnt_d = '0;
          if (ready) begin
            start   = 1'b1;
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_l = (ORDER == 0) ? rd_first : rd_second;
  assign rd_r = (ORDER == 0) ? rd_second : rd_first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wl_q      <= '0;
      wr_q      <= '0;
      sop_cap_q <= 1'b0;
      sof_cap_q <= 1'b0;
      pl_q      <= '0;
      pr_q      <= '0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
      pix_tag_q <= '0;
      v1_q      <= 1'b0;
      sel_l1_q  <= 1'b0;
      first1_q  <= 1'b0;
      last1_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (bus.valid_l_i) begin
        wl_q <= wl_last ? '0 : wl_q + WLW'(1);
        if (wl_first) begin
          sop_cap_q <= bus.sop_i;
          sof_cap_q <= bus.sof_i;
        end
      end
      if (bus.valid_r_i) wr_q <= wr_last ? '0 : wr_q + WRW'(1);
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      // Tag FIFO output is valid on the first read cycle; hold it for the whole pixel.
      if (rd_first && rcnt_q == '0) pix_tag_q <= tag_out;
      v1_q     <= rd_first || rd_second;
      sel_l1_q <= rd_l;
      first1_q <= rd_first && (rcnt_q == '0);
      last1_q  <= rd_second && (rcnt_q == CW'(CH_SECOND - 1));
      data_q   <= v1_q ? (sel_l1_q ? ql : qr) : '0;
      valid_q  <= v1_q;
      sop_q    <= v1_q && first1_q && pix_tag_q.sop;
      sof_q    <= v1_q && first1_q && pix_tag_q.sof;
      eop_q    <= v1_q && last1_q && pix_tag_q.eop;
      eof_q    <= v1_q && last1_q && pix_tag_q.eof;
      ovf_q    <= ovf_q || drop_l || drop_r || drop_t;
    end
  end

  assign bus.data_o       = data_q;
  assign bus.data_valid_o = valid_q;
  assign bus.sop_o        = sop_q;
  assign bus.eop_o        = eop_q;
  assign bus.sof_o        = sof_q;
  assign bus.eof_o        = eof_q;
  assign bus.ovf_o        = ovf_q;
endmodule

// File: tb/tb_concat_channels_n.sv
// Scoreboard bench for concat_channels_n: three configurations (16/16 order 0,
// 4/2 order 1, 16/16 with shallow FIFOs for overflow).
module tb_concat_channels_n;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  concat_channels_n_if #(.DATA_WIDTH(8)) ifa ();
  concat_channels_n_if #(.DATA_WIDTH(8)) ifb ();
  concat_channels_n_if #(.DATA_WIDTH(8)) ifc ();

  concat_channels_n #(.DATA_WIDTH(8), .CH_L(16), .CH_R(16), .FIFO_DEPTH(64),
                      .TAG_DEPTH(4), .ORDER(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  concat_channels_n #(.DATA_WIDTH(8), .CH_L(4), .CH_R(2), .FIFO_DEPTH(8),
                      .TAG_DEPTH(4), .ORDER(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  concat_channels_n #(.DATA_WIDTH(8), .CH_L(16), .CH_R(16), .FIFO_DEPTH(16),
                      .TAG_DEPTH(4), .ORDER(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  // Scoreboard for instance A: entry = {data, sop, eop, sof, eof}
  logic [11:0] exp_a[$];
  int          start_a[$];
  int          idx_a = 0;
  logic        prev_va = 1'b0;
  logic [11:0] got_a, e_a;
  int          ldone[8];
  int          rdone[8];

  always @(negedge clk) begin
    if (reset) begin
      idx_a   = 0;
      prev_va = 1'b0;
    end else if (ifa.data_valid_o) begin
      got_a = {ifa.data_o, ifa.sop_o, ifa.eop_o, ifa.sof_o, ifa.eof_o};
      if (idx_a == 0) start_a.push_back(cyc);
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL mon_a_unexpected: got=%h required=none", got_a);
      end else begin
        e_a = exp_a.pop_front();
        if (got_a !== e_a) begin
          errors++;
          $display("FAIL mon_a_word idx=%0d: got=%h required=%h", idx_a, got_a, e_a);
        end
      end
      if (idx_a != 0) begin
        checks++;
        if (!prev_va) begin
          errors++;
          $display("FAIL mon_a_contig idx=%0d: prev_valid=0 required=1", idx_a);
        end
      end
      idx_a   = (idx_a + 1) % 32;
      prev_va = 1'b1;
    end else begin
      checks++;
      if ({ifa.sop_o, ifa.eop_o, ifa.sof_o, ifa.eof_o} !== 4'b0) begin
        errors++;
        $display("FAIL mon_a_idle_flags: got=%b required=0000",
                 {ifa.sop_o, ifa.eop_o, ifa.sof_o, ifa.eof_o});
      end
      prev_va = 1'b0;
    end
  end

  task automatic drive_l_a(int npix, int skew, int base, bit sop, bit eop, bit sof, bit eof);
    repeat (skew) @(posedge clk);
    for (int p = 0; p < npix; p++) begin
      for (int w = 0; w < 16; w++) begin
        @(posedge clk); #1;
        ifa.valid_l_i = 1'b1;
        ifa.data_l_i  = 8'(base + p*16 + w);
        ifa.sop_i     = sop && (w == 0);
        ifa.eop_i     = eop && (w == 15);
        ifa.sof_i     = sof && (p == 0) && (w == 0);
        ifa.eof_i     = eof && (p == npix-1) && (w == 15);
        if (w == 15) ldone[p] = cyc;
      end
    end
    @(posedge clk); #1;
    ifa.valid_l_i = 1'b0;
    {ifa.sop_i, ifa.eop_i, ifa.sof_i, ifa.eof_i} = 4'b0;
  endtask

  task automatic drive_r_a(int npix, int skew, int base);
    repeat (skew) @(posedge clk);
    for (int p = 0; p < npix; p++) begin
      for (int w = 0; w < 16; w++) begin
        @(posedge clk); #1;
        ifa.valid_r_i = 1'b1;
        ifa.data_r_i  = 8'(base + p*16 + w);
        if (w == 15) rdone[p] = cyc;
      end
    end
    @(posedge clk); #1;
    ifa.valid_r_i = 1'b0;
  endtask

  task automatic drive_a(int npix, int lskew, int rskew, int lbase, int rbase,
                         bit sop, bit eop, bit sof, bit eof);
    logic [11:0] e;
    for (int p = 0; p < npix; p++) begin
      for (int j = 0; j < 32; j++) begin
        e[11:4] = (j < 16) ? 8'(lbase + p*16 + j) : 8'(rbase + p*16 + j - 16);
        e[3] = sop && (j == 0);
        e[2] = eop && (j == 31);
        e[1] = sof && (p == 0) && (j == 0);
        e[0] = eof && (p == npix-1) && (j == 31);
        exp_a.push_back(e);
      end
    end
    fork
      drive_l_a(npix, lskew, lbase, sop, eop, sof, eof);
      drive_r_a(npix, rskew, rbase);
    join
  endtask

  task automatic wait_drain_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #2;
      if (exp_a.size() == 0 && !ifa.data_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.data_o, ifa.data_valid_o, ifa.sop_o, ifa.eop_o, ifa.sof_o, ifa.eof_o, ifa.ovf_o} !== 15'b0) begin
      errors++;
      $display("FAIL reset_a_outputs: got=%h required=0",
               {ifa.data_o, ifa.data_valid_o, ifa.sop_o, ifa.eop_o, ifa.sof_o, ifa.eof_o, ifa.ovf_o});
    end
    checks++;
    if ({ifb.data_valid_o, ifb.ovf_o, ifc.data_valid_o, ifc.ovf_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_bc_outputs: got=%b required=0000",
               {ifb.data_valid_o, ifb.ovf_o, ifc.data_valid_o, ifc.ovf_o});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.data_valid_o, ifa.ovf_o} !== 2'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got=%b required=00", {ifa.data_valid_o, ifa.ovf_o});
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    start_a.delete();
    drive_a(1, 0, 0, 0, 100, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_drain: timeout, left=%0d required=0", exp_a.size()); end
    checks++;
    if (start_a.size() != 1) begin
      errors++;
      $display("FAIL basic_pixels: got=%0d required=1", start_a.size());
    end else begin
      lat = start_a[0] - ((ldone[0] > rdone[0]) ? ldone[0] : rdone[0]);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL basic_latency: got=%0d required=4", lat); end
    end
  endtask

  task automatic test_order();
    logic [11:0] exp_b[$];
    logic [11:0] got, e;
    logic [7:0]  lv[4];
    logic [7:0]  rv[2];
    int n = 0;
    logic prev = 1'b0;
    lv = '{8'd1, 8'd2, 8'd3, 8'd4};
    rv = '{8'd9, 8'd8};
    exp_b.push_back({8'd9, 4'b1000});
    exp_b.push_back({8'd8, 4'b0000});
    exp_b.push_back({8'd1, 4'b0000});
    exp_b.push_back({8'd2, 4'b0000});
    exp_b.push_back({8'd3, 4'b0000});
    exp_b.push_back({8'd4, 4'b0100});
    fork
      begin
        for (int w = 0; w < 4; w++) begin
          @(posedge clk); #1;
          ifb.valid_l_i = 1'b1; ifb.data_l_i = lv[w];
          ifb.sop_i = (w == 0); ifb.eop_i = (w == 3);
        end
        @(posedge clk); #1;
        ifb.valid_l_i = 1'b0; ifb.sop_i = 1'b0; ifb.eop_i = 1'b0;
      end
      begin
        for (int w = 0; w < 2; w++) begin
          @(posedge clk); #1;
          ifb.valid_r_i = 1'b1; ifb.data_r_i = rv[w];
        end
        @(posedge clk); #1;
        ifb.valid_r_i = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (ifb.data_valid_o) begin
            got = {ifb.data_o, ifb.sop_o, ifb.eop_o, ifb.sof_o, ifb.eof_o};
            checks++;
            if (exp_b.size() == 0) begin
              errors++; $display("FAIL order_unexpected: got=%h required=none", got);
            end else begin
              e = exp_b.pop_front();
              if (got !== e) begin errors++; $display("FAIL order_word%0d: got=%h required=%h", n, got, e); end
            end
            if (n != 0) begin
              checks++;
              if (!prev) begin errors++; $display("FAIL order_contig%0d: prev_valid=0 required=1", n); end
            end
            n++;
          end
          prev = ifb.data_valid_o;
        end
      end
    join
    checks++;
    if (n != 6) begin errors++; $display("FAIL order_count: got=%0d required=6", n); end
  endtask

  task automatic test_skew();
    bit ok;
    int lat;
    start_a.delete();
    drive_a(3, 0, 20, 20, 150, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL skew_drain: timeout, left=%0d required=0", exp_a.size()); end
    checks++;
    if (start_a.size() != 3) begin
      errors++;
      $display("FAIL skew_pixels: got=%0d required=3", start_a.size());
    end else begin
      lat = start_a[0] - rdone[0];
      checks++;
      if (lat != 4) begin errors++; $display("FAIL skew_latency: got=%0d required=4", lat); end
      for (int p = 1; p < 3; p++) begin
        checks++;
        if (start_a[p] - start_a[p-1] != 32) begin
          errors++;
          $display("FAIL skew_back_to_back%0d: gap=%0d required=32", p, start_a[p] - start_a[p-1]);
        end
      end
    end
  endtask

  task automatic test_frame();
    bit ok;
    start_a.delete();
    drive_a(2, 0, 0, 30, 60, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_drain_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_drain: timeout, left=%0d required=0", exp_a.size()); end
    checks++;
    if (start_a.size() != 2) begin errors++; $display("FAIL frame_pixels: got=%0d required=2", start_a.size()); end
  endtask

  task automatic test_overflow();
    int n = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (i == 16) begin
        checks++;
        if (ifc.ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_before: got=%b required=0", ifc.ovf_o); end
      end
      if (i == 17) begin
        checks++;
        if (ifc.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_rise: got=%b required=1", ifc.ovf_o); end
      end
      ifc.valid_l_i = 1'b1; ifc.data_l_i = 8'(i);
      ifc.sop_i = (i % 16 == 0); ifc.eop_i = (i % 16 == 15);
    end
    @(posedge clk); #1;
    ifc.valid_l_i = 1'b0; ifc.sop_i = 1'b0; ifc.eop_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ifc.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got=%b required=1", ifc.ovf_o); end
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          @(posedge clk); #1;
          ifc.valid_r_i = 1'b1; ifc.data_r_i = 8'(100 + i);
        end
        @(posedge clk); #1;
        ifc.valid_r_i = 1'b0;
      end
      begin
        for (int i = 0; i < 400 && n < 64; i++) begin
          @(negedge clk);
          if (ifc.data_valid_o) begin
            checks++;
            if ({ifc.sop_o, ifc.eop_o} !== {n % 32 == 0, n % 32 == 31}) begin
              errors++;
              $display("FAIL ovf_flags word%0d: got=%b required=%b", n, {ifc.sop_o, ifc.eop_o},
                       {n % 32 == 0, n % 32 == 31});
            end
            if (n < 32) begin
              checks++;
              if (ifc.data_o !== ((n < 16) ? 8'(n) : 8'(100 + n - 16))) begin
                errors++;
                $display("FAIL ovf_data word%0d: got=%0d required=%0d", n, ifc.data_o,
                         (n < 16) ? n : 100 + n - 16);
              end
            end
            n++;
          end
        end
      end
    join
    checks++;
    if (n != 64) begin errors++; $display("FAIL ovf_count: got=%0d required=64", n); end
    checks++;
    if (ifc.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_end: got=%b required=1", ifc.ovf_o); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit = 1'b0;
    int lat;
    drive_a(1, 0, 0, 10, 200, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (idx_a == 10) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_reach: idx=%0d required=10", idx_a); end
    reset = 1'b1;
    #1;
    checks++;
    if ({ifa.data_o, ifa.data_valid_o, ifa.sop_o, ifa.eop_o, ifa.sof_o, ifa.eof_o, ifa.ovf_o} !== 15'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got=%h required=0",
               {ifa.data_o, ifa.data_valid_o, ifa.sop_o, ifa.eop_o, ifa.sof_o, ifa.eof_o, ifa.ovf_o});
    end
    exp_a.delete();
    start_a.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    drive_a(1, 0, 0, 40, 80, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_drain_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_drain: timeout, left=%0d required=0", exp_a.size()); end
    checks++;
    if (start_a.size() != 1) begin
      errors++;
      $display("FAIL rstmid_pixels: got=%0d required=1", start_a.size());
    end else begin
      lat = start_a[0] - ((ldone[0] > rdone[0]) ? ldone[0] : rdone[0]);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL rstmid_latency: got=%0d required=4", lat); end
    end
  endtask

  initial begin
    reset = 1'b1;
    {ifa.valid_l_i, ifa.valid_r_i, ifa.sop_i, ifa.eop_i, ifa.sof_i, ifa.eof_i} = 6'b0;
    {ifb.valid_l_i, ifb.valid_r_i, ifb.sop_i, ifb.eop_i, ifb.sof_i, ifb.eof_i} = 6'b0;
    {ifc.valid_l_i, ifc.valid_r_i, ifc.sop_i, ifc.eop_i, ifc.sof_i, ifc.eof_i} = 6'b0;
    ifa.data_l_i = '0; ifa.data_r_i = '0;
    ifb.data_l_i = '0; ifb.data_r_i = '0;
    ifc.data_l_i = '0; ifc.data_r_i = '0;
    test_reset();
    test_basic();
    test_order();
    test_skew();
    test_frame();
    test_overflow();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
